jogo_sequencia_memoria: RTL and testbench

Simon-style memory game core. A 16-entry fixed colour sequence is stored in ROM. In round r (0..15), the player must repeat entries 0..r on four buttons. The block contains the control FSM, address/round counters, a play register, a button edge detector, a timeout counter and 7-segment debug encoders. It sits at the top of the FPGA game design.

---
 rtl/jogo_sequencia_memoria.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_jogo_sequencia_memoria.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jogo_sequencia_memoria.sv
// -----------------------------------------------------------------------------
// jogo_sequencia_memoria
//
// Core of a Simon-style memory game. A fixed 16-entry colour sequence lives in
// a ROM. In round r (0..15) the player must repeat entries 0..r on four
// one-hot buttons. A wrong press or a timeout loses the game. Correctly
// repeating the whole 16-entry sequence wins it.
//
// Parameters:
//   TIMEOUT_CICLOS : clock cycles allowed while waiting for a press
//
// Ports:
//   clock                   in   system clock
//   reset                   in   asynchronous active-high reset
//   jogar                   in   start / restart request (level)
//   botoes[3:0]             in   one-hot buttons, active-high
//   leds[3:0]               out  combinational copy of botoes
//   ganhou / perdeu / pronto out game won / game lost / game finished
//   db_contagem             out  7-seg of the play address counter
//   db_memoria              out  7-seg of ROM[address]
//   db_estado               out  7-seg of the FSM state code
//   db_jogadafeita          out  7-seg of the registered play
//   db_rodada               out  7-seg of the round counter
//   db_clock                out  copy of clock
//   db_jogada_correta       out  registered play matches ROM[address]
//   db_tem_jogada           out  one-cycle pulse on a new button press
//   db_enderecoIgualRodada  out  address counter equals round counter
//   db_timeout              out  wait-for-play counter has expired
// -----------------------------------------------------------------------------
module jogo_sequencia_memoria #(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic [3:0] botoes,
    output logic [3:0] leds,
    output logic       ganhou,
    output logic       perdeu,
    output logic       pronto,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogadafeita,
    output logic [6:0] db_rodada,
    output logic       db_clock,
    output logic       db_jogada_correta,
    output logic       db_tem_jogada,
    output logic       db_enderecoIgualRodada,
    output logic       db_timeout
);

    // Timeout counter width: enough bits to hold TIMEOUT_CICLOS-1.
    localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CICLOS - 1);

    // State encodings double as the hex digit shown on db_estado.
    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        ESPERA_JOGADA  = 4'h2,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTO     = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERRO       = 4'hE
    } estado_t;

    // -------------------------------------------------------------------------
    // Fixed colour sequence
    // -------------------------------------------------------------------------
    function automatic logic [3:0] rom_dado(input logic [3:0] endereco);
        logic [3:0] dado;
        case (endereco)
            4'd0:    dado = 4'b0001;
            4'd1:    dado = 4'b0010;
            4'd2:    dado = 4'b0100;
            4'd3:    dado = 4'b1000;
            4'd4:    dado = 4'b0100;
            4'd5:    dado = 4'b0010;
            4'd6:    dado = 4'b0001;
            4'd7:    dado = 4'b0001;
            4'd8:    dado = 4'b0010;
            4'd9:    dado = 4'b0010;
            4'd10:   dado = 4'b0100;
            4'd11:   dado = 4'b0100;
            4'd12:   dado = 4'b1000;
            4'd13:   dado = 4'b1000;
            4'd14:   dado = 4'b0001;
            default: dado = 4'b0100;
        endcase
        return dado;
    endfunction

    // -------------------------------------------------------------------------
    // Hex to 7-segment, active-low, bit order gfedcba
    // -------------------------------------------------------------------------
    function automatic logic [6:0] hex7seg(input logic [3:0] valor);
        logic [6:0] seg;
        case (valor)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // -------------------------------------------------------------------------
    // State, counters and registers
    // -------------------------------------------------------------------------
    estado_t       estado_q,   estado_d;
    logic [3:0]    endereco_q, endereco_d;
    logic [3:0]    rodada_q,   rodada_d;
    logic [3:0]    jogada_q,   jogada_d;
    logic          botao_q,    botao_d;
    logic [TW-1:0] timeout_q,  timeout_d;

    // Control strobes from the FSM
    logic zera_e;
    logic conta_e;
    logic zera_r;
    logic conta_r;
    logic registra;

    // Datapath status
    logic       algum_botao;
    logic       tem_jogada;
    logic [3:0] memoria;
    logic       jogada_correta;
    logic       endereco_igual_rodada;
    logic       timeout_expirou;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= INICIAL;
            endereco_q <= '0;
            rodada_q   <= '0;
            jogada_q   <= '0;
            botao_q    <= 1'b0;
            timeout_q  <= '0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            rodada_q   <= rodada_d;
            jogada_q   <= jogada_d;
            botao_q    <= botao_d;
            timeout_q  <= timeout_d;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    assign algum_botao           = |botoes;
    // Rising edge of "any button": a held button yields a single pulse.
    assign tem_jogada            = algum_botao & ~botao_q;
    assign memoria               = rom_dado(endereco_q);
    assign jogada_correta        = (jogada_q == memoria);
    assign endereco_igual_rodada = (endereco_q == rodada_q);
    assign timeout_expirou       = (timeout_q == TIMEOUT_MAX);

    always_comb begin
        botao_d    = algum_botao;
        endereco_d = endereco_q;
        rodada_d   = rodada_q;
        jogada_d   = jogada_q;
        timeout_d  = '0;

        // Clear has priority; in proxima_rodada both zera_e and conta_r fire,
        // so the address restarts at 0 for the new round.
        if (zera_e) begin
            endereco_d = '0;
        end else if (conta_e) begin
            endereco_d = endereco_q + 4'd1;
        end

        if (zera_r) begin
            rodada_d = '0;
        end else if (conta_r) begin
            rodada_d = rodada_q + 4'd1;
        end

        if (zera_r) begin
            jogada_d = '0;
        end else if (registra) begin
            jogada_d = botoes;
        end

        // Only the wait-for-play state accumulates time; the count saturates
        // so db_timeout stays visible until the FSM leaves that state.
        if (estado_q == ESPERA_JOGADA) begin
            timeout_d = timeout_expirou ? timeout_q : timeout_q + TW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM: next state and Moore outputs
    // -------------------------------------------------------------------------
    always_comb begin
        estado_d = estado_q;
        zera_e   = 1'b0;
        conta_e  = 1'b0;
        zera_r   = 1'b0;
        conta_r  = 1'b0;
        registra = 1'b0;
        ganhou   = 1'b0;
        perdeu   = 1'b0;
        pronto   = 1'b0;

        case (estado_q)
            INICIAL: begin
                if (jogar) begin
                    estado_d = PREPARACAO;
                end
            end
            PREPARACAO: begin
                zera_e   = 1'b1;
                zera_r   = 1'b1;
                estado_d = ESPERA_JOGADA;
            end
            ESPERA_JOGADA: begin
                // A press wins over a timeout expiring in the same cycle.
                if (tem_jogada) begin
                    estado_d = REGISTRA;
                end else if (timeout_expirou) begin
                    estado_d = FIM_TIMEOUT;
                end
            end
            REGISTRA: begin
                registra = 1'b1;
                estado_d = COMPARACAO;
            end
            COMPARACAO: begin
                if (!jogada_correta) begin
                    estado_d = FIM_ERRO;
                end else if (!endereco_igual_rodada) begin
                    estado_d = PROXIMA_JOGADA;
                end else if (rodada_q == 4'd15) begin
                    estado_d = FIM_ACERTO;
                end else begin
                    estado_d = PROXIMA_RODADA;
                end
            end
            PROXIMA_JOGADA: begin
                conta_e  = 1'b1;
                estado_d = ESPERA_JOGADA;
            end
            PROXIMA_RODADA: begin
                conta_r  = 1'b1;
                zera_e   = 1'b1;
                estado_d = ESPERA_JOGADA;
            end
            FIM_ACERTO: begin
                pronto = 1'b1;
                ganhou = 1'b1;
                if (jogar) begin
                    estado_d = PREPARACAO;
                end
            end
            FIM_ERRO, FIM_TIMEOUT: begin
                pronto = 1'b1;
                perdeu = 1'b1;
                if (jogar) begin
                    estado_d = PREPARACAO;
                end
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Debug outputs
    // -------------------------------------------------------------------------
    // Five 7-segment displays, in the order:
    // contagem, memoria, estado, jogadafeita, rodada.
    logic [3:0] hex_in  [5];
    logic [6:0] hex_out [5];

    assign hex_in[0] = endereco_q;
    assign hex_in[1] = memoria;
    assign hex_in[2] = estado_q;
    assign hex_in[3] = jogada_q;
    assign hex_in[4] = rodada_q;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_hex
            assign hex_out[gi] = hex7seg(hex_in[gi]);
        end
    endgenerate

    assign db_contagem    = hex_out[0];
    assign db_memoria     = hex_out[1];
    assign db_estado      = hex_out[2];
    assign db_jogadafeita = hex_out[3];
    assign db_rodada      = hex_out[4];

    assign leds                   = botoes;
    assign db_clock               = clock;
    assign db_jogada_correta      = jogada_correta;
    assign db_tem_jogada          = tem_jogada;
    assign db_enderecoIgualRodada = endereco_igual_rodada;
    assign db_timeout             = timeout_expirou;

endmodule

// File: tb/tb_jogo_sequencia_memoria.sv
// -----------------------------------------------------------------------------
// Bench for jogo_sequencia_memoria. The reference model follows the game
// rules directly: a sequence array plus the current round/address, updated
// per press (wrong -> loss, last entry of round 15 -> win, end of round ->
// next round, otherwise next address).
// -----------------------------------------------------------------------------
module tb_jogo_sequencia_memoria;

    localparam int TIMEOUT = 5000;

    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [3:0] SEQ [16] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
        4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100
    };

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       jogar = 1'b0;
    logic [3:0] botoes = 4'b0000;
    logic [3:0] leds;
    logic       ganhou, perdeu, pronto;
    logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_rodada;
    logic       db_clock, db_jogada_correta, db_tem_jogada;
    logic       db_enderecoIgualRodada, db_timeout;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_round;
    int m_addr;
    int m_state;

    always #10 clock = ~clock;

    jogo_sequencia_memoria #(.TIMEOUT_CICLOS(TIMEOUT)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .jogar                  (jogar),
        .botoes                 (botoes),
        .leds                   (leds),
        .ganhou                 (ganhou),
        .perdeu                 (perdeu),
        .pronto                 (pronto),
        .db_contagem            (db_contagem),
        .db_memoria             (db_memoria),
        .db_estado              (db_estado),
        .db_jogadafeita         (db_jogadafeita),
        .db_rodada              (db_rodada),
        .db_clock               (db_clock),
        .db_jogada_correta      (db_jogada_correta),
        .db_tem_jogada          (db_tem_jogada),
        .db_enderecoIgualRodada (db_enderecoIgualRodada),
        .db_timeout             (db_timeout)
    );

    // Game rules applied to one press.
    task automatic model_reset();
        m_round = 0;
        m_addr  = 0;
        m_state = 2;
    endtask

    task automatic model_play(input logic [3:0] v);
        if (v != SEQ[m_addr]) begin
            m_state = 14;
        end else if (m_addr < m_round) begin
            m_addr++;
        end else if (m_round == 15) begin
            m_state = 10;
        end else begin
            m_round++;
            m_addr = 0;
        end
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic press(input logic [3:0] v, input int gap);
        botoes = v;
        repeat (5) @(posedge clock);
        #1 botoes = 4'b0000;
        repeat (gap) @(posedge clock);
        #1;
    endtask

    task automatic start_game();
        @(posedge clock);
        #1 jogar = 1'b1;
        repeat (5) @(posedge clock);
        #1 jogar = 1'b0;
        model_reset();
    endtask

    function automatic logic [3:0] wrong_of(input logic [3:0] v, input int s);
        logic [3:0] w;
        w = v;
        for (int k = 0; k < s; k++) w = {w[2:0], w[3]};
        return w;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        checks++;
        if (db_estado !== SEG[0]) begin
            errors++; $display("FAIL reset_state got=%b exp=%b", db_estado, SEG[0]);
        end
        checks++;
        if ({pronto, ganhou, perdeu} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got=%b exp=000", {pronto, ganhou, perdeu});
        end
        checks++;
        if (db_contagem !== SEG[0] || db_rodada !== SEG[0]) begin
            errors++; $display("FAIL reset_counters got=%b/%b exp=%b", db_contagem, db_rodada, SEG[0]);
        end
        for (int i = 0; i < 6; i++) begin
            logic [3:0] v;
            v = 4'($urandom_range(0, 15));
            botoes = v;
            #1;
            checks++;
            if (leds !== v) begin
                errors++; $display("FAIL leds_mirror got=%b exp=%b", leds, v);
            end
        end
        botoes = 4'b0000;
        repeat (3) @(posedge clock);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_full_game();
        start_game();
        for (int p = 0; p < 136; p++) begin
            logic [3:0] v;
            v = SEQ[m_addr];
            press(v, 5 + $urandom_range(0, 3));
            model_play(v);
            $display("play %0d: pressed %b round=%0d addr=%0d state=%0h", p, v, m_round, m_addr, m_state);
            checks++;
            if (db_estado !== SEG[m_state]) begin
                errors++; $display("FAIL full_state play=%0d got=%b exp=%b", p, db_estado, SEG[m_state]);
            end
            checks++;
            if (db_rodada !== SEG[m_round] || db_contagem !== SEG[m_addr]) begin
                errors++; $display("FAIL full_counters play=%0d got=%b/%b exp=%b/%b",
                                   p, db_rodada, db_contagem, SEG[m_round], SEG[m_addr]);
            end
            checks++;
            if (db_jogadafeita !== SEG[v]) begin
                errors++; $display("FAIL full_jogada play=%0d got=%b exp=%b", p, db_jogadafeita, SEG[v]);
            end
        end
        checks++;
        if ({ganhou, pronto, perdeu} !== 3'b110) begin
            errors++; $display("FAIL win_flags got=%b exp=110", {ganhou, pronto, perdeu});
        end
        checks++;
        if (db_estado !== SEG[10] || db_rodada !== SEG[15]) begin
            errors++; $display("FAIL win_display got=%b/%b exp=%b/%b", db_estado, db_rodada, SEG[10], SEG[15]);
        end
    endtask

    task automatic test_restart();
        @(posedge clock);
        #1 jogar = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (db_estado !== SEG[1] || pronto !== 1'b0 || ganhou !== 1'b0 || perdeu !== 1'b0) begin
            errors++; $display("FAIL restart_prep got=%b p=%b g=%b l=%b exp=%b 0 0 0",
                               db_estado, pronto, ganhou, perdeu, SEG[1]);
        end
        @(posedge clock);
        #1;
        checks++;
        if (db_estado !== SEG[2] || db_contagem !== SEG[0] || db_rodada !== SEG[0]
            || db_jogadafeita !== SEG[0]) begin
            errors++; $display("FAIL restart_wait got=%b cnt=%b rod=%b jog=%b exp=%b and zeros",
                               db_estado, db_contagem, db_rodada, db_jogadafeita, SEG[2]);
        end
        repeat (8) @(posedge clock);
        #1 jogar = 1'b0;
        checks++;
        if (db_estado !== SEG[2]) begin
            errors++; $display("FAIL restart_hold got=%b exp=%b", db_estado, SEG[2]);
        end
        model_reset();
        $display("test_restart done");
    endtask

    // Continues from the game started by test_restart.
    task automatic test_random_error();
        int r, a, s;
        bit done;
        r = $urandom_range(1, 5);
        a = $urandom_range(0, r);
        s = $urandom_range(1, 3);
        done = 0;
        for (int rr = 0; rr <= r && !done; rr++) begin
            for (int aa = 0; aa <= rr && !done; aa++) begin
                logic [3:0] v;
                v = (rr == r && aa == a) ? wrong_of(SEQ[aa], s) : SEQ[aa];
                press(v, 5);
                model_play(v);
                $display("rand play r=%0d a=%0d pressed %b state=%0h", rr, aa, v, m_state);
                checks++;
                if (db_estado !== SEG[m_state]) begin
                    errors++; $display("FAIL rand_state r=%0d a=%0d got=%b exp=%b", rr, aa, db_estado, SEG[m_state]);
                end
                if (m_state == 14) done = 1;
            end
        end
        checks++;
        if ({ganhou, perdeu, pronto} !== 3'b011) begin
            errors++; $display("FAIL rand_flags got=%b exp=011", {ganhou, perdeu, pronto});
        end
    endtask

    task automatic test_wrong_play();
        logic [3:0] plays [3];
        plays = '{4'b0001, 4'b0001, 4'b0100};
        start_game();
        for (int i = 0; i < 3; i++) begin
            press(plays[i], 5);
            model_play(plays[i]);
            $display("wrong test play %0d pressed %b state=%0h", i, plays[i], m_state);
            checks++;
            if (db_estado !== SEG[m_state]) begin
                errors++; $display("FAIL wrong_state play=%0d got=%b exp=%b", i, db_estado, SEG[m_state]);
            end
        end
        checks++;
        if ({ganhou, perdeu, pronto} !== 3'b011) begin
            errors++; $display("FAIL wrong_flags got=%b exp=011", {ganhou, perdeu, pronto});
        end
    endtask

    task automatic test_timeout();
        int k;
        bit seen;
        start_game();
        seen = 0;
        k = 0;
        // Espera is entered two edges after jogar rises; counting starts there,
        // and db_timeout rises after TIMEOUT-1 further edges.
        while (!seen && k < TIMEOUT + 20) begin
            @(posedge clock);
            #1;
            k++;
            if (db_timeout === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || k != TIMEOUT - 4) begin
            errors++; $display("FAIL timeout_cycle seen=%0d got=%0d exp=%0d", seen, k, TIMEOUT - 4);
        end
        @(posedge clock);
        #1;
        $display("timeout after %0d cycles, state=%b", k, db_estado);
        checks++;
        if (db_estado !== SEG[13] || {perdeu, pronto, ganhou} !== 3'b110) begin
            errors++; $display("FAIL timeout_end got=%b flags=%b exp=%b 110", db_estado,
                               {perdeu, pronto, ganhou}, SEG[13]);
        end
    endtask

    task automatic test_reset_midgame();
        bit spurious;
        start_game();
        for (int rr = 0; rr < 3; rr++) begin
            for (int aa = 0; aa <= rr; aa++) begin
                press(SEQ[aa], 5);
                model_play(SEQ[aa]);
            end
        end
        checks++;
        if (db_rodada !== SEG[m_round] || db_estado !== SEG[2]) begin
            errors++; $display("FAIL mid_round got=%b/%b exp=%b/%b", db_rodada, db_estado, SEG[m_round], SEG[2]);
        end
        botoes = SEQ[0];
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        $display("reset asserted mid-press in round %0d", m_round);
        checks++;
        if (db_estado !== SEG[0] || db_rodada !== SEG[0] || db_contagem !== SEG[0]
            || db_jogadafeita !== SEG[0] || pronto !== 1'b0) begin
            errors++; $display("FAIL mid_async got=%b rod=%b cnt=%b jog=%b p=%b exp=%b",
                               db_estado, db_rodada, db_contagem, db_jogadafeita, pronto, SEG[0]);
        end
        #2 botoes = 4'b0000;
        @(posedge clock);
        #1 reset = 1'b0;
        spurious = 0;
        repeat (10) begin
            @(posedge clock);
            #1;
            if (db_tem_jogada !== 1'b0 || db_estado !== SEG[0]) spurious = 1;
        end
        checks++;
        if (spurious) begin
            errors++; $display("FAIL mid_after got=spurious activity exp=idle state 0");
        end
    endtask

    initial begin
        test_reset();
        test_full_game();
        test_restart();
        test_random_error();
        test_wrong_play();
        test_timeout();
        test_reset_midgame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop so a stuck design cannot hang the run.
    initial begin
        #4000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
